mem_responder: RTL and testbench



---
 rtl/mem_responder.sv | 221 ++++++++++++++++++++++
 tb/tb_mem_responder.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Memory-side responder for the CPU data port. A CPU read or write request on
// a 16-bit byte address is executed as one (byte) or two (word) accesses to a
// byte-wide synchronous SRAM with a one-cycle read latency. Word data is
// little-endian: the low byte lives at the even address, the high byte at +1.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   rst          asynchronous, active-high reset
//   addr         byte address of the request
//   wr_data      write data (byte writes use [7:0])
//   rd_mem       read request
//   wr_mem       write request (wins over rd_mem when both are high)
//   byt          1 = byte access, 0 = word access
//   rd_data      read result, byte reads zero-extended; holds until next read
//   ready        one-cycle completion pulse
//   busy         request in progress
//   err          pulses with ready when the completed request was malformed
//   mem_addr     SRAM byte address
//   mem_wdata    SRAM write data
//   mem_we       SRAM write enable
//   mem_re       SRAM read enable
//   mem_rdata    SRAM read data, valid the cycle after mem_re
//   dbg_state_o  current FSM state, for observation only
//
// Request handshake: a request is taken on any rising edge where the FSM is
// IDLE and rd_mem or wr_mem is high; the inputs are sampled on that edge only
// and need not be held afterwards. Requests presented while busy, or during
// the DONE cycle, are ignored (not queued). Completion is signalled by a single
// ready pulse; the requester re-presents a held request and it is taken on the
// edge that ends the cycle after ready.
//
// Every output is a register loaded from the next-state decode, so the SRAM
// side has no combinational path from the CPU request inputs.
// -----------------------------------------------------------------------------
module mem_responder (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] wr_data,
    input  logic        rd_mem,
    input  logic        wr_mem,
    input  logic        byt,
    output logic [15:0] rd_data,
    output logic        ready,
    output logic        busy,
    output logic        err,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_LO  = 3'd1,
        RD_HI  = 3'd2,
        RD_FIN = 3'd3,
        WR_LO  = 3'd4,
        WR_HI  = 3'd5,
        DONE   = 3'd6
    } state_t;

    // FSM state and latched request
    state_t      state_q, state_d;
    logic [15:0] a_q, a_d;          // request address, already rounded for words
    logic [15:0] wd_q, wd_d;        // request write data
    logic        byt_q, byt_d;      // request is a byte access
    logic        eflag_q, eflag_d;  // request was malformed
    logic [7:0]  rlo_q, rlo_d;      // low byte of a word read in flight

    // Registered outputs
    logic [15:0] rd_data_q, rd_data_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        mem_we_q, mem_we_d;
    logic        mem_re_q, mem_re_d;

    // -------------------------------------------------------------------------
    // Next-state and next-output decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        wd_d      = wd_q;
        byt_d     = byt_q;
        eflag_d   = eflag_q;
        rlo_d     = rlo_q;
        rd_data_d = rd_data_q;

        case (state_q)
            IDLE: begin
                if (wr_mem || rd_mem) begin
                    // Word accesses are forced onto an even address; an odd
                    // word address or a simultaneous read+write is flagged.
                    a_d     = byt ? addr : (addr & 16'hFFFE);
                    wd_d    = wr_data;
                    byt_d   = byt;
                    eflag_d = (rd_mem && wr_mem) || (!byt && addr[0]);
                    state_d = wr_mem ? WR_LO : RD_LO;
                end
            end
            RD_LO: begin
                state_d = byt_q ? RD_FIN : RD_HI;
            end
            RD_HI: begin
                // mem_rdata now carries the byte requested in RD_LO
                rlo_d   = mem_rdata;
                state_d = RD_FIN;
            end
            RD_FIN: begin
                rd_data_d = byt_q ? {8'h00, mem_rdata} : {mem_rdata, rlo_q};
                state_d   = DONE;
            end
            WR_LO: begin
                state_d = byt_q ? DONE : WR_HI;
            end
            WR_HI: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the state being entered so that they are
        // registered together with it and line up with that state's cycle.
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = 16'h0000;
        mem_wdata_d = 8'h00;
        case (state_d)
            RD_LO: begin
                mem_re_d   = 1'b1;
                mem_addr_d = a_d;
            end
            RD_HI: begin
                mem_re_d   = 1'b1;
                mem_addr_d = a_d | 16'h0001;
            end
            WR_LO: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = a_d;
                mem_wdata_d = wd_d[7:0];
            end
            WR_HI: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = a_d | 16'h0001;
                mem_wdata_d = wd_d[15:8];
            end
            default: begin
                mem_re_d    = 1'b0;
                mem_we_d    = 1'b0;
                mem_addr_d  = 16'h0000;
                mem_wdata_d = 8'h00;
            end
        endcase

        ready_d = (state_d == DONE);
        err_d   = (state_d == DONE) && eflag_d;
        busy_d  = (state_d != IDLE);
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= 16'h0000;
            wd_q        <= 16'h0000;
            byt_q       <= 1'b0;
            eflag_q     <= 1'b0;
            rlo_q       <= 8'h00;
            rd_data_q   <= 16'h0000;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 8'h00;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            wd_q        <= wd_d;
            byt_q       <= byt_d;
            eflag_q     <= eflag_d;
            rlo_q       <= rlo_d;
            rd_data_q   <= rd_data_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
        end
    end

    assign rd_data     = rd_data_q;
    assign ready       = ready_q;
    assign busy        = busy_q;
    assign err         = err_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_we      = mem_we_q;
    assign mem_re      = mem_re_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] wr_data;
  logic        rd_mem;
  logic        wr_mem;
  logic        byt;
  logic [15:0] rd_data;
  logic        ready;
  logic        busy;
  logic        err;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata;
  logic [2:0]  dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_responder dut (
    .clk         (clk),
    .rst         (rst),
    .addr        (addr),
    .wr_data     (wr_data),
    .rd_mem      (rd_mem),
    .wr_mem      (wr_mem),
    .byt         (byt),
    .rd_data     (rd_data),
    .ready       (ready),
    .busy        (busy),
    .err         (err),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_re      (mem_re),
    .mem_rdata   (mem_rdata),
    .dbg_state_o (dbg_state)
  );

  // Byte-wide synchronous SRAM, one-cycle read latency
  logic [7:0] sram [0:65535];
  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= sram[mem_addr];
  end

  int cmp_cnt = 0;
  int mis_cnt = 0;

  // Watchdog: the run must always end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt + 1);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Driver: issue one request, then observe cycles 1..7 after acceptance
  // ---------------------------------------------------------------------------
  int          cap_ready_cyc;
  int          cap_ready_cnt;
  int          cap_err_cnt;
  logic        cap_err_at_ready;
  logic [15:0] cap_rd_at_ready;
  logic        cap_busy1;
  logic        cap_busy_after;
  logic        cap_overlap;
  int          cap_re_cnt;
  int          cap_we_cnt;
  logic [15:0] cap_re_addr [4];
  logic [15:0] cap_we_addr [4];
  logic [7:0]  cap_we_data [4];

  task automatic run_req(input logic rd, input logic wr, input logic b,
                         input logic [15:0] a, input logic [15:0] wd);
    cap_ready_cyc    = 0;
    cap_ready_cnt    = 0;
    cap_err_cnt      = 0;
    cap_err_at_ready = 1'bx;
    cap_rd_at_ready  = 16'hxxxx;
    cap_busy1        = 1'bx;
    cap_busy_after   = 1'bx;
    cap_overlap      = 1'b0;
    cap_re_cnt       = 0;
    cap_we_cnt       = 0;
    for (int i = 0; i < 4; i++) begin
      cap_re_addr[i] = 16'hxxxx;
      cap_we_addr[i] = 16'hxxxx;
      cap_we_data[i] = 8'hxx;
    end
    @(negedge clk);
    rd_mem = rd; wr_mem = wr; byt = b; addr = a; wr_data = wd;
    @(posedge clk);  // acceptance edge, cycle 0
    #1;
    rd_mem = 1'b0; wr_mem = 1'b0; byt = 1'b0; addr = 16'h0; wr_data = 16'h0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) cap_busy1 = busy;
      if (mem_re) begin
        if (cap_re_cnt < 4) cap_re_addr[cap_re_cnt] = mem_addr;
        cap_re_cnt++;
      end
      if (mem_we) begin
        if (cap_we_cnt < 4) begin
          cap_we_addr[cap_we_cnt] = mem_addr;
          cap_we_data[cap_we_cnt] = mem_wdata;
        end
        cap_we_cnt++;
      end
      if (mem_re && mem_we) cap_overlap = 1'b1;
      if (err) cap_err_cnt++;
      if (ready) cap_ready_cnt++;
      if (cap_ready_cyc != 0 && c == cap_ready_cyc + 1) cap_busy_after = busy;
      if (ready && cap_ready_cyc == 0) begin
        cap_ready_cyc    = c;
        cap_rd_at_ready  = rd_data;
        cap_err_at_ready = err;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd_mem  = 1'b1;
    wr_mem  = 1'($urandom_range(0, 1));
    byt     = 1'($urandom_range(0, 1));
    addr    = 16'($urandom_range(0, 65535));
    wr_data = 16'($urandom_range(0, 65535));
    @(posedge clk);
    @(negedge clk);  // mid-cycle of the first access state
    rst = 1'b1;
    #1;
    cmp_cnt++; if (mem_re !== 1'b0) begin mis_cnt++; $display("FAIL rst_mem_re: got %b want 0", mem_re); end
    cmp_cnt++; if (mem_we !== 1'b0) begin mis_cnt++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    cmp_cnt++; if (mem_addr !== 16'h0) begin mis_cnt++; $display("FAIL rst_mem_addr: got %h want 0000", mem_addr); end
    cmp_cnt++; if (mem_wdata !== 8'h0) begin mis_cnt++; $display("FAIL rst_mem_wdata: got %h want 00", mem_wdata); end
    cmp_cnt++; if (ready !== 1'b0) begin mis_cnt++; $display("FAIL rst_ready: got %b want 0", ready); end
    cmp_cnt++; if (busy !== 1'b0) begin mis_cnt++; $display("FAIL rst_busy: got %b want 0", busy); end
    cmp_cnt++; if (err !== 1'b0) begin mis_cnt++; $display("FAIL rst_err: got %b want 0", err); end
    cmp_cnt++; if (rd_data !== 16'h0) begin mis_cnt++; $display("FAIL rst_rd_data: got %h want 0000", rd_data); end
    rd_mem = 1'b0; wr_mem = 1'b0; byt = 1'b0; addr = 16'h0; wr_data = 16'h0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cmp_cnt++; if (busy !== 1'b0) begin mis_cnt++; $display("FAIL rel_busy: got %b want 0", busy); end
    cmp_cnt++; if (dbg_state !== 3'd0) begin mis_cnt++; $display("FAIL rel_state: got %0d want 0", dbg_state); end
  endtask

  task automatic test_word_write();
    run_req(1'b0, 1'b1, 1'b0, 16'h0100, 16'hBEEF);
    cmp_cnt++; if (cap_ready_cyc != 3) begin mis_cnt++; $display("FAIL ww_ready_cycle: got %0d want 3", cap_ready_cyc); end
    cmp_cnt++; if (cap_ready_cnt != 1) begin mis_cnt++; $display("FAIL ww_ready_count: got %0d want 1", cap_ready_cnt); end
    cmp_cnt++; if (cap_err_at_ready !== 1'b0) begin mis_cnt++; $display("FAIL ww_err: got %b want 0", cap_err_at_ready); end
    cmp_cnt++; if (cap_we_cnt != 2) begin mis_cnt++; $display("FAIL ww_we_count: got %0d want 2", cap_we_cnt); end
    cmp_cnt++; if (cap_we_addr[0] !== 16'h0100) begin mis_cnt++; $display("FAIL ww_addr0: got %h want 0100", cap_we_addr[0]); end
    cmp_cnt++; if (cap_we_data[0] !== 8'hEF) begin mis_cnt++; $display("FAIL ww_data0: got %h want EF", cap_we_data[0]); end
    cmp_cnt++; if (cap_we_addr[1] !== 16'h0101) begin mis_cnt++; $display("FAIL ww_addr1: got %h want 0101", cap_we_addr[1]); end
    cmp_cnt++; if (cap_we_data[1] !== 8'hBE) begin mis_cnt++; $display("FAIL ww_data1: got %h want BE", cap_we_data[1]); end
    cmp_cnt++; if (cap_re_cnt != 0) begin mis_cnt++; $display("FAIL ww_re_count: got %0d want 0", cap_re_cnt); end
    cmp_cnt++; if (cap_busy1 !== 1'b1) begin mis_cnt++; $display("FAIL ww_busy_c1: got %b want 1", cap_busy1); end
    cmp_cnt++; if (cap_busy_after !== 1'b0) begin mis_cnt++; $display("FAIL ww_busy_after: got %b want 0", cap_busy_after); end
  endtask

  task automatic test_word_read();
    run_req(1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000);
    cmp_cnt++; if (cap_ready_cyc != 4) begin mis_cnt++; $display("FAIL wr_ready_cycle: got %0d want 4", cap_ready_cyc); end
    cmp_cnt++; if (cap_rd_at_ready !== 16'hBEEF) begin mis_cnt++; $display("FAIL wr_rd_data: got %h want BEEF", cap_rd_at_ready); end
    cmp_cnt++; if (cap_re_cnt != 2) begin mis_cnt++; $display("FAIL wr_re_count: got %0d want 2", cap_re_cnt); end
    cmp_cnt++; if (cap_re_addr[0] !== 16'h0100) begin mis_cnt++; $display("FAIL wr_addr0: got %h want 0100", cap_re_addr[0]); end
    cmp_cnt++; if (cap_re_addr[1] !== 16'h0101) begin mis_cnt++; $display("FAIL wr_addr1: got %h want 0101", cap_re_addr[1]); end
    cmp_cnt++; if (cap_err_cnt != 0) begin mis_cnt++; $display("FAIL wr_err_count: got %0d want 0", cap_err_cnt); end
    cmp_cnt++; if (cap_we_cnt != 0) begin mis_cnt++; $display("FAIL wr_we_count: got %0d want 0", cap_we_cnt); end
    cmp_cnt++; if (cap_busy_after !== 1'b0) begin mis_cnt++; $display("FAIL wr_busy_after: got %b want 0", cap_busy_after); end
    cmp_cnt++; if (rd_data !== 16'hBEEF) begin mis_cnt++; $display("FAIL wr_rd_hold: got %h want BEEF", rd_data); end
  endtask

  task automatic test_byte();
    run_req(1'b0, 1'b1, 1'b1, 16'h0203, 16'h995A);
    cmp_cnt++; if (cap_ready_cyc != 2) begin mis_cnt++; $display("FAIL bw_ready_cycle: got %0d want 2", cap_ready_cyc); end
    cmp_cnt++; if (cap_we_cnt != 1) begin mis_cnt++; $display("FAIL bw_we_count: got %0d want 1", cap_we_cnt); end
    cmp_cnt++; if (cap_we_addr[0] !== 16'h0203) begin mis_cnt++; $display("FAIL bw_addr: got %h want 0203", cap_we_addr[0]); end
    cmp_cnt++; if (cap_we_data[0] !== 8'h5A) begin mis_cnt++; $display("FAIL bw_data: got %h want 5A", cap_we_data[0]); end
    cmp_cnt++; if (rd_data !== 16'hBEEF) begin mis_cnt++; $display("FAIL bw_rd_unchanged: got %h want BEEF", rd_data); end
    run_req(1'b1, 1'b0, 1'b1, 16'h0203, 16'h0000);
    cmp_cnt++; if (cap_ready_cyc != 3) begin mis_cnt++; $display("FAIL br_ready_cycle: got %0d want 3", cap_ready_cyc); end
    cmp_cnt++; if (cap_re_cnt != 1) begin mis_cnt++; $display("FAIL br_re_count: got %0d want 1", cap_re_cnt); end
    cmp_cnt++; if (cap_re_addr[0] !== 16'h0203) begin mis_cnt++; $display("FAIL br_addr: got %h want 0203", cap_re_addr[0]); end
    cmp_cnt++; if (cap_rd_at_ready !== 16'h005A) begin mis_cnt++; $display("FAIL br_rd_data: got %h want 005A", cap_rd_at_ready); end
    cmp_cnt++; if (cap_err_cnt != 0) begin mis_cnt++; $display("FAIL br_err_count: got %0d want 0", cap_err_cnt); end
  endtask

  task automatic test_odd_word();
    run_req(1'b1, 1'b0, 1'b0, 16'h0101, 16'h0000);
    cmp_cnt++; if (cap_re_addr[0] !== 16'h0100) begin mis_cnt++; $display("FAIL odd_addr0: got %h want 0100", cap_re_addr[0]); end
    cmp_cnt++; if (cap_re_addr[1] !== 16'h0101) begin mis_cnt++; $display("FAIL odd_addr1: got %h want 0101", cap_re_addr[1]); end
    cmp_cnt++; if (cap_ready_cyc != 4) begin mis_cnt++; $display("FAIL odd_ready_cycle: got %0d want 4", cap_ready_cyc); end
    cmp_cnt++; if (cap_err_at_ready !== 1'b1) begin mis_cnt++; $display("FAIL odd_err_at_ready: got %b want 1", cap_err_at_ready); end
    cmp_cnt++; if (cap_err_cnt != 1) begin mis_cnt++; $display("FAIL odd_err_count: got %0d want 1", cap_err_cnt); end
    cmp_cnt++; if (cap_rd_at_ready !== 16'hBEEF) begin mis_cnt++; $display("FAIL odd_rd_data: got %h want BEEF", cap_rd_at_ready); end
  endtask

  task automatic test_both();
    run_req(1'b1, 1'b1, 1'b0, 16'h0300, 16'h1234);
    cmp_cnt++; if (cap_re_cnt != 0) begin mis_cnt++; $display("FAIL both_re_count: got %0d want 0", cap_re_cnt); end
    cmp_cnt++; if (cap_we_cnt != 2) begin mis_cnt++; $display("FAIL both_we_count: got %0d want 2", cap_we_cnt); end
    cmp_cnt++; if (cap_err_at_ready !== 1'b1) begin mis_cnt++; $display("FAIL both_err: got %b want 1", cap_err_at_ready); end
    cmp_cnt++; if (cap_ready_cyc != 3) begin mis_cnt++; $display("FAIL both_ready_cycle: got %0d want 3", cap_ready_cyc); end
    cmp_cnt++; if (cap_overlap !== 1'b0) begin mis_cnt++; $display("FAIL both_re_we_overlap: got %b want 0", cap_overlap); end
    cmp_cnt++; if (rd_data !== 16'hBEEF) begin mis_cnt++; $display("FAIL both_rd_unchanged: got %h want BEEF", rd_data); end
    run_req(1'b1, 1'b0, 1'b0, 16'h0300, 16'h0000);
    cmp_cnt++; if (cap_rd_at_ready !== 16'h1234) begin mis_cnt++; $display("FAIL both_readback: got %h want 1234", cap_rd_at_ready); end
    cmp_cnt++; if (cap_err_at_ready !== 1'b0) begin mis_cnt++; $display("FAIL both_err_cleared: got %b want 0", cap_err_at_ready); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rdy_mask;
    logic [15:0] busy_mask;
    logic [15:0] rd_c14;
    rdy_mask  = 16'h0;
    busy_mask = 16'h0;
    rd_c14    = 16'h0;
    @(negedge clk);
    rd_mem = 1'b1; byt = 1'b0; addr = 16'h0100;
    @(posedge clk);  // first acceptance, cycle 0
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      rdy_mask[c]  = ready;
      busy_mask[c] = busy;
      if (c == 14) rd_c14 = rd_data;
    end
    rd_mem = 1'b0; addr = 16'h0;
    repeat (6) @(negedge clk);
    cmp_cnt++; if (rdy_mask !== 16'h4210) begin mis_cnt++; $display("FAIL b2b_ready_mask: got %h want 4210", rdy_mask); end
    cmp_cnt++; if (busy_mask !== 16'h7BDE) begin mis_cnt++; $display("FAIL b2b_busy_mask: got %h want 7BDE", busy_mask); end
    cmp_cnt++; if (rd_c14 !== 16'hBEEF) begin mis_cnt++; $display("FAIL b2b_rd_data: got %h want BEEF", rd_c14); end
    cmp_cnt++; if (busy !== 1'b0) begin mis_cnt++; $display("FAIL b2b_idle_after: got %b want 0", busy); end
  endtask

  task automatic test_reset_abort();
    logic ready_seen;
    sram[16'h0400] = 8'h11;
    sram[16'h0401] = 8'h77;
    @(negedge clk);
    wr_mem = 1'b1; byt = 1'b0; addr = 16'h0400; wr_data = 16'hCAFE;
    @(posedge clk);
    #1;
    wr_mem = 1'b0; addr = 16'h0; wr_data = 16'h0;
    @(negedge clk);  // cycle 1: WR_LO
    cmp_cnt++; if (mem_wdata !== 8'hFE) begin mis_cnt++; $display("FAIL abort_lo_data: got %h want FE", mem_wdata); end
    @(negedge clk);  // cycle 2: WR_HI
    cmp_cnt++; if (mem_addr !== 16'h0401) begin mis_cnt++; $display("FAIL abort_hi_addr: got %h want 0401", mem_addr); end
    rst = 1'b1;
    #1;
    cmp_cnt++; if (mem_we !== 1'b0) begin mis_cnt++; $display("FAIL abort_we_cleared: got %b want 0", mem_we); end
    ready_seen = 1'b0;
    repeat (2) begin @(negedge clk); ready_seen = ready_seen | ready; end
    rst = 1'b0;
    repeat (4) begin @(negedge clk); ready_seen = ready_seen | ready; end
    cmp_cnt++; if (ready_seen !== 1'b0) begin mis_cnt++; $display("FAIL abort_no_ready: got %b want 0", ready_seen); end
    cmp_cnt++; if (sram[16'h0400] !== 8'hFE) begin mis_cnt++; $display("FAIL abort_lo_written: got %h want FE", sram[16'h0400]); end
    cmp_cnt++; if (sram[16'h0401] !== 8'h77) begin mis_cnt++; $display("FAIL abort_hi_untouched: got %h want 77", sram[16'h0401]); end
    run_req(1'b1, 1'b0, 1'b0, 16'h0400, 16'h0000);
    cmp_cnt++; if (cap_ready_cyc != 4) begin mis_cnt++; $display("FAIL post_abort_ready: got %0d want 4", cap_ready_cyc); end
    cmp_cnt++; if (cap_rd_at_ready !== 16'h77FE) begin mis_cnt++; $display("FAIL post_abort_rd: got %h want 77FE", cap_rd_at_ready); end
    cmp_cnt++; if (cap_err_at_ready !== 1'b0) begin mis_cnt++; $display("FAIL post_abort_err: got %b want 0", cap_err_at_ready); end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1; rd_mem = 1'b0; wr_mem = 1'b0; byt = 1'b0;
    addr = 16'h0; wr_data = 16'h0;
    repeat (2) @(negedge clk);
    test_reset();
    test_word_write();
    test_word_read();
    test_byte();
    test_odd_word();
    test_both();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
